// File: rtl/fifo_pkg.sv
// Shared constants, pointer-width helper and status-flag struct for the FIFO buffer.
package fifo_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultDepth = 16;

  // Pointers carry one extra wrap bit above the storage index.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
    logic underflow;
  } status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one synchronous read port, no reset.
module fifo_ram #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rd_data_q;

  // Write on strobe; read register only updates on an accepted read so it holds otherwise.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with registered status, sticky overflow/underflow and 1-cycle read latency.
// Optional almost_full/almost_empty outputs are built when FIFO_ALMOST_FLAGS_EN is defined.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned ALMOST_TH = 2,
  localparam int unsigned PtrW     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_put,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en_get,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [PtrW-1:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   count_q, count_d;
  status_t           status_q, status_d;
  logic              rd_valid_q;
  logic              put_ok, get_ok;
  logic [DATA_W-1:0] ram_rd_data;

  // Next-state for pointers, occupancy and flags; status is judged on pre-edge values.
  always_comb begin
    status_d           = status_q;
    put_ok             = en_put && !status_q.full;
    get_ok             = en_get && !status_q.empty;
    wr_ptr_d           = wr_ptr_q + PtrW'(put_ok);
    rd_ptr_d           = rd_ptr_q + PtrW'(get_ok);
    count_d            = count_q + PtrW'(put_ok) - PtrW'(get_ok);
    status_d.empty     = (wr_ptr_d == rd_ptr_d);
    status_d.full      = (wr_ptr_d[PtrW-1] != rd_ptr_d[PtrW-1]) &&
                         (wr_ptr_d[PtrW-2:0] == rd_ptr_d[PtrW-2:0]);
    status_d.overflow  = status_q.overflow | (en_put & status_q.full);
    status_d.underflow = status_q.underflow | (en_get & status_q.empty);
  end

  // State registers; flags come out of flops so there is no input-to-status path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      status_q   <= '{full: 1'b0, empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      status_q   <= status_d;
      rd_valid_q <= rd_valid_q | get_ok;
    end
  end

  fifo_ram #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (put_ok),
    .wr_addr_i (wr_ptr_q[PtrW-2:0]),
    .wr_data_i (data_in),
    .rd_en_i   (get_ok),
    .rd_addr_i (rd_ptr_q[PtrW-2:0]),
    .rd_data_o (ram_rd_data)
  );

  // The RAM read register has no reset; mask it to zero until a get has loaded it since reset.
  assign data_out  = rd_valid_q ? ram_rd_data : '0;
  assign full      = status_q.full;
  assign empty     = status_q.empty;
  assign count     = count_q;
  assign overflow  = status_q.overflow;
  assign underflow = status_q.underflow;

`ifdef FIFO_ALMOST_FLAGS_EN
  logic almost_full_q, almost_empty_q;

  // Almost flags track post-edge occupancy like the other status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= PtrW'(DEPTH - ALMOST_TH));
      almost_empty_q <= (count_d <= PtrW'(ALMOST_TH));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: occupancy/flag model plus a data scoreboard queue.
module tb_fifo_buffer;

  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 16;
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned AlmTh = 2;

  logic             clk;
  logic             rst_n;
  logic             en_put;
  logic [DataW-1:0] data_in;
  logic             en_get;
  logic [DataW-1:0] data_out;
  logic             full;
  logic             empty;
  logic [CntW-1:0]  count;
  logic             overflow;
  logic             underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  fifo_buffer #(
    .DATA_W    (DataW),
    .DEPTH     (Depth),
    .ALMOST_TH (AlmTh)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_put    (en_put),
    .data_in   (data_in),
    .en_get    (en_get),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [DataW-1:0] sb_q [$];
  int               m_count = 0;
  logic             m_ovf   = 1'b0;
  logic             m_unf   = 1'b0;
  logic [DataW-1:0] m_dout  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".full"}, 32'(full), 32'(m_count == Depth));
    check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`ifdef FIFO_ALMOST_FLAGS_EN
    check({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= int'(Depth - AlmTh)));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_count <= int'(AlmTh)));
`endif
  endtask

  // One clock of stimulus; called at edge+1 and returns at the next edge+1.
  task automatic step(input logic put, input logic [DataW-1:0] din, input logic get,
                      input logic chk_status);
    logic put_ok, get_ok;
    put_ok  = put && (m_count != Depth);
    get_ok  = get && (m_count != 0);
    en_put  = put;
    data_in = din;
    en_get  = get;
    if (put_ok) sb_q.push_back(din);
    if (put && !put_ok) m_ovf = 1'b1;
    if (get && !get_ok) m_unf = 1'b1;
    m_count = m_count + int'(put_ok) - int'(get_ok);
    @(posedge clk);
    #1;
    en_put = 1'b0;
    en_get = 1'b0;
    if (get_ok) m_dout = sb_q.pop_front();
    check(get_ok ? "rd_data" : "rd_hold", 32'(data_out), 32'(m_dout));
    if (chk_status) check_status("step");
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_dout  = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    en_put  = 1'b0;
    en_get  = 1'b0;
    data_in = '0;
    #12;
    check("reset.data_out", 32'(data_out), 32'h0);
    check_status("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) step(1'b1, DataW'(i), 1'b0, 1'b1);
    check_status("filled");

    // Put while full is dropped and sets overflow
    step(1'b1, 8'hAA, 1'b0, 1'b1);

    // Drain in order
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    check("drained.last", 32'(data_out), 32'h0F);

    // Get on empty: underflow, data_out holds
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Hold occupancy at 8 with 40 cycles of simultaneous put/get
    for (int i = 0; i < 8; i++) step(1'b1, DataW'(8'h40 + i), 1'b0, 1'b0);
    check_status("at8");
    for (int i = 0; i < 40; i++) step(1'b1, DataW'($urandom_range(0, 255)), 1'b1, 1'b1);

    // Full with same-cycle get: put dropped, get accepted
    for (int i = 0; i < 8; i++) step(1'b1, DataW'(8'h80 + i), 1'b0, 1'b0);
    check_status("refull");
    step(1'b1, 8'h55, 1'b1, 1'b1);

    // Drain to 5 entries, then reset mid-burst away from any clock edge
    while (m_count > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("at5");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.data_out", 32'(data_out), 32'h0);
    check_status("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status("postrst");

    // Get while empty with same-cycle put: get dropped, put accepted
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // Walk occupancy up and down to cross the almost thresholds
    for (int i = 0; i < 16; i++) step(1'b1, DataW'(8'hC0 + i), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
    check("sb.empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
